// File: rtl/register_scoreboard_if.sv
// Issue/writeback bus for the register scoreboard.
// master: the issue/writeback source; slave: the scoreboard itself.
interface register_scoreboard_if #(
    parameter int CNT_W = 2
);
    logic               issue_valid;
    logic               issue_wb_en;
    logic [3:0]         issue_dest;
    logic               with_src1;
    logic               with_src2;
    logic [3:0]         src1;
    logic [3:0]         src2;
    logic               wb_valid;
    logic [3:0]         wb_dest;
    logic               has_hazard;
    logic               dest_full;
    logic               stall;
    logic               issue_fire;
    logic               any_pending;
    logic [CNT_W+3:0]   inflight_total;
    logic               err_underflow;

    modport master (
        output issue_valid, issue_wb_en, issue_dest, with_src1, with_src2,
               src1, src2, wb_valid, wb_dest,
        input  has_hazard, dest_full, stall, issue_fire, any_pending,
               inflight_total, err_underflow
    );

    modport slave (
        input  issue_valid, issue_wb_en, issue_dest, with_src1, with_src2,
               src1, src2, wb_valid, wb_dest,
        output has_hazard, dest_full, stall, issue_fire, any_pending,
               inflight_total, err_underflow
    );
endinterface

// File: rtl/register_scoreboard.sv
// Register scoreboard: one saturating pending-write counter per register,
// hazard/stall decode for the presented instruction, sticky underflow flag.
module register_scoreboard #(
    parameter int CNT_W = 2
) (
    input  logic clk,
    input  logic rst,
    register_scoreboard_if.slave sb
);
    localparam int TOT_W = CNT_W + 4;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] pend_cnt_q [16];
    logic [CNT_W-1:0] pend_cnt_d [16];
    logic             err_underflow_q;
    logic             err_underflow_d;
    logic [TOT_W-1:0] total;
    logic             hazard;
    logic             full;
    logic             stall;
    logic             fire;
    logic             same_reg;

    // Issue-side decode; looks only at registered counts, so a writeback in
    // the same cycle never bypasses into the hazard.
    always_comb begin
        hazard = (sb.with_src1 && (pend_cnt_q[sb.src1] != '0)) ||
                 (sb.with_src2 && (pend_cnt_q[sb.src2] != '0));
        full   = (pend_cnt_q[sb.issue_dest] == CNT_MAX);
        stall  = sb.issue_valid && (hazard || (sb.issue_wb_en && full));
        fire   = sb.issue_valid && sb.issue_wb_en && !stall;
    end

    // Counter next-state: an issue and a writeback to the same register cancel.
    always_comb begin
        pend_cnt_d      = pend_cnt_q;
        err_underflow_d = err_underflow_q;
        same_reg        = fire && sb.wb_valid && (sb.issue_dest == sb.wb_dest);
        if (!same_reg) begin
            if (fire) begin
                pend_cnt_d[sb.issue_dest] = pend_cnt_q[sb.issue_dest] + CNT_W'(1);
            end
            if (sb.wb_valid) begin
                if (pend_cnt_q[sb.wb_dest] != '0) begin
                    pend_cnt_d[sb.wb_dest] = pend_cnt_q[sb.wb_dest] - CNT_W'(1);
                end else begin
                    err_underflow_d = 1'b1;
                end
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) begin
                pend_cnt_q[i] <= '0;
            end
            err_underflow_q <= 1'b0;
        end else begin
            pend_cnt_q      <= pend_cnt_d;
            err_underflow_q <= err_underflow_d;
        end
    end

    // Occupancy summary, derived from registered counters only.
    always_comb begin
        total = '0;
        for (int i = 0; i < 16; i++) begin
            total = total + TOT_W'(pend_cnt_q[i]);
        end
    end

    assign sb.has_hazard     = hazard;
    assign sb.dest_full      = full;
    assign sb.stall          = stall;
    assign sb.issue_fire     = fire;
    assign sb.any_pending    = (total != '0);
    assign sb.inflight_total = total;
    assign sb.err_underflow  = err_underflow_q;
endmodule

// File: tb/tb_register_scoreboard.sv
// Self-checking bench for register_scoreboard: directed scenarios followed by
// randomized traffic, all compared against a behavioural model.
module tb_register_scoreboard;
    localparam int CNT_W = 2;
    localparam int MAXC  = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    register_scoreboard_if #(.CNT_W(CNT_W)) sb ();

    register_scoreboard #(.CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .sb  (sb.slave)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int model_cnt [16];
    bit model_err;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    endtask

    function automatic bit m_hazard();
        return (sb.with_src1 && model_cnt[sb.src1] > 0) ||
               (sb.with_src2 && model_cnt[sb.src2] > 0);
    endfunction

    function automatic bit m_full();
        return model_cnt[sb.issue_dest] == MAXC;
    endfunction

    function automatic bit m_stall();
        return sb.issue_valid && (m_hazard() || (sb.issue_wb_en && m_full()));
    endfunction

    function automatic bit m_fire();
        return sb.issue_valid && sb.issue_wb_en && !m_stall();
    endfunction

    function automatic int m_total();
        int s = 0;
        foreach (model_cnt[i]) s += model_cnt[i];
        return s;
    endfunction

    // Apply inputs, let them settle, compare every output with the model.
    task automatic drv(input bit v, input bit wben, input int d,
                       input bit ws1, input int s1, input bit ws2, input int s2,
                       input bit wv, input int wd, input bit r);
        sb.issue_valid = v;
        sb.issue_wb_en = wben;
        sb.issue_dest  = 4'(d);
        sb.with_src1   = ws1;
        sb.src1        = 4'(s1);
        sb.with_src2   = ws2;
        sb.src2        = 4'(s2);
        sb.wb_valid    = wv;
        sb.wb_dest     = 4'(wd);
        rst            = r;
        #2;
        check_eq("has_hazard",     sb.has_hazard,     m_hazard());
        check_eq("dest_full",      sb.dest_full,      m_full());
        check_eq("stall",          sb.stall,          m_stall());
        check_eq("issue_fire",     sb.issue_fire,     m_fire());
        check_eq("inflight_total", sb.inflight_total, m_total());
        check_eq("any_pending",    sb.any_pending,    m_total() != 0);
        check_eq("err_underflow",  sb.err_underflow,  model_err);
    endtask

    task automatic idle(input bit ws1 = 0, input int s1 = 0);
        drv(0, 0, 0, ws1, s1, 0, 0, 0, 0, 0);
    endtask

    // Advance one clock edge and apply the same edge to the model.
    task automatic tick();
        bit fire = m_fire();
        bit wv   = sb.wb_valid;
        int d    = sb.issue_dest;
        int wd   = sb.wb_dest;
        @(posedge clk);
        if (rst) begin
            foreach (model_cnt[i]) model_cnt[i] = 0;
            model_err = 0;
        end else if (!(fire && wv && d == wd)) begin
            if (fire) model_cnt[d]++;
            if (wv) begin
                if (model_cnt[wd] > 0) model_cnt[wd]--;
                else model_err = 1;
            end
        end
        #1;
    endtask

    initial begin
        foreach (model_cnt[i]) model_cnt[i] = 0;
        model_err = 0;
        @(posedge clk);
        #1;
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 1); tick();
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 1); tick();

        // Reset state, query r3.
        idle(1, 3);
        check_eq("rst_hazard", sb.has_hazard, 0);
        check_eq("rst_total", sb.inflight_total, 0);
        check_eq("rst_any", sb.any_pending, 0);
        tick();

        // Issue r5, hazard next cycle, cleared one cycle after writeback.
        drv(1, 1, 5, 0, 0, 0, 0, 0, 0, 0);
        check_eq("r5_fire", sb.issue_fire, 1);
        tick();
        drv(0, 0, 0, 0, 0, 1, 5, 0, 0, 0);
        check_eq("r5_hazard", sb.has_hazard, 1);
        tick();
        drv(0, 0, 0, 0, 0, 1, 5, 1, 5, 0);
        check_eq("r5_no_bypass", sb.has_hazard, 1);
        tick();
        drv(0, 0, 0, 0, 0, 1, 5, 0, 0, 0);
        check_eq("r5_cleared", sb.has_hazard, 0);
        tick();

        // Saturate r7, fourth issue stalls.
        for (int i = 0; i < 3; i++) begin
            drv(1, 1, 7, 0, 0, 0, 0, 0, 0, 0);
            tick();
        end
        drv(1, 1, 7, 0, 0, 0, 0, 0, 0, 0);
        check_eq("r7_full", sb.dest_full, 1);
        check_eq("r7_stall", sb.stall, 1);
        check_eq("r7_nofire", sb.issue_fire, 0);
        check_eq("r7_total", sb.inflight_total, 3);
        tick();
        idle();
        check_eq("r7_total_hold", sb.inflight_total, 3);
        for (int i = 0; i < 3; i++) begin
            drv(0, 0, 0, 0, 0, 0, 0, 1, 7, 0);
            tick();
        end

        // Same-cycle issue and writeback to r2 with count 1 cancel out.
        drv(1, 1, 2, 0, 0, 0, 0, 0, 0, 0); tick();
        drv(1, 1, 2, 0, 2, 0, 0, 1, 2, 0); tick();
        idle(1, 2);
        check_eq("r2_hold_hazard", sb.has_hazard, 1);
        check_eq("r2_hold_total", sb.inflight_total, 1);
        drv(0, 0, 0, 1, 2, 0, 0, 1, 2, 0);
        check_eq("r2_wb_no_bypass", sb.has_hazard, 1);
        tick();

        // Underflow on r9, sticky, cleared by reset.
        drv(0, 0, 0, 0, 0, 0, 0, 1, 9, 0); tick();
        idle();
        check_eq("err_set", sb.err_underflow, 1);
        tick(); tick();
        idle();
        check_eq("err_held", sb.err_underflow, 1);
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 1); tick();
        idle();
        check_eq("err_cleared", sb.err_underflow, 0);
        tick();

        // Issue r4 while writing back r6.
        drv(1, 1, 6, 0, 0, 0, 0, 0, 0, 0); tick();
        drv(1, 1, 4, 0, 0, 0, 0, 1, 6, 0); tick();
        drv(0, 0, 0, 1, 4, 0, 0, 0, 0, 0);
        check_eq("r4_pending", sb.has_hazard, 1);
        check_eq("r4r6_total", sb.inflight_total, 1);
        tick();
        drv(0, 0, 0, 0, 0, 1, 6, 0, 0, 0);
        check_eq("r6_clear", sb.has_hazard, 0);
        tick();

        // Reset with a write in flight discards it; later writeback underflows.
        drv(1, 1, 1, 0, 0, 0, 0, 0, 0, 1); tick();
        drv(1, 1, 1, 0, 0, 0, 0, 0, 0, 0); tick();
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 1); tick();
        drv(0, 0, 0, 0, 0, 0, 0, 1, 1, 0); tick();
        idle();
        check_eq("rst_discard_err", sb.err_underflow, 1);
        tick();

        // Randomized traffic, biased towards a few registers and real writebacks.
        for (int n = 0; n < 1500; n++) begin
            int d, wd, s1, s2;
            bit wv;
            d  = ($urandom % 2) ? int'($urandom % 4) : int'($urandom % 16);
            s1 = ($urandom % 2) ? int'($urandom % 4) : int'($urandom % 16);
            s2 = int'($urandom % 16);
            wv = ($urandom % 3) == 0;
            wd = int'($urandom % 16);
            if ($urandom % 20 != 0) begin
                for (int k = 0; k < 16; k++) begin
                    int c = (wd + k) % 16;
                    if (model_cnt[c] > 0) begin
                        wd = c;
                        break;
                    end
                end
            end
            drv($urandom % 2, ($urandom % 4) != 0, d,
                $urandom % 2, s1, $urandom % 2, s2,
                wv, wd, ($urandom % 60) == 0);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/register_scoreboard.md
REGISTER_SCOREBOARD -- requirements
Module: register_scoreboard

Interface
REQ-001 The module SHALL have one parameter: CNT_W, default 2, the width of each per-register pending counter. The maximum in-flight writes per register is 2^CNT_W-1.
REQ-002 The ports SHALL be as follows:
- clk  in  1  the only clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- issue_valid  in  1  an instruction is presented for issue this cycle.
- issue_wb_en  in  1  the presented instruction writes a register.
- issue_dest  in  4  destination register of the presented instruction.
- with_src1  in  1  the presented instruction reads src1.
- with_src2  in  1  the presented instruction reads src2.
- src1  in  4  first source register.
- src2  in  4  second source register.
- wb_valid  in  1  a register writeback completes this cycle.
- wb_dest  in  4  register being written back.
- has_hazard  out  1  a used source has a pending write (combinational).
- dest_full  out  1  the pending counter of issue_dest is saturated (combinational).
- stall  out  1  equals issue_valid & (has_hazard | (issue_wb_en & dest_full)).
- issue_fire  out  1  equals issue_valid & issue_wb_en & ~stall.
- any_pending  out  1  at least one counter is nonzero (registered state, decoded combinationally).
- inflight_total  out  CNT_W+4  sum of all 16 counters.
- err_underflow  out  1  sticky flag: a writeback arrived for a register whose counter was 0.

Function
REQ-003 The block SHALL hold 16 counters, pend_cnt[0..15], each CNT_W bits wide.
REQ-004 has_hazard SHALL be 1 when either of these holds, else 0:
- with_src1 & pend_cnt[src1]!=0
- with_src2 & pend_cnt[src2]!=0
REQ-005 has_hazard SHALL be computed from registered counts only. There is no writeback bypass: a same-cycle wb_valid to a queried register does not clear the hazard in that cycle.
REQ-006 dest_full SHALL be 1 when pend_cnt[issue_dest] equals 2^CNT_W-1.
REQ-007 When issue_fire=1, pend_cnt[issue_dest] SHALL increment at the next clock edge.
REQ-008 When wb_valid=1 and pend_cnt[wb_dest]!=0, that counter SHALL decrement at the next clock edge.
REQ-009 When issue_fire=1, wb_valid=1 and issue_dest==wb_dest, that counter SHALL remain unchanged, including when it is saturated or 0.
REQ-010 When issue_fire=1 and wb_valid=1 with different registers, both updates SHALL apply in the same edge.
REQ-011 When wb_valid=1 and pend_cnt[wb_dest]==0, and the REQ-009 case does not apply:
- the counter SHALL stay 0;
- err_underflow SHALL be set at the next edge;
- err_underflow SHALL hold 1 until rst.
REQ-012 A counter SHALL never wrap. Saturation is prevented by dest_full gating issue_fire, so no increment past 2^CNT_W-1 occurs.
REQ-013 Latency: an issue at edge N SHALL make its register hazardous from cycle N+1. A writeback at edge N SHALL clear the hazard from cycle N+1 when the count reaches 0.
REQ-014 issue_wb_en=0 or issue_valid=0 SHALL leave all counters unchanged apart from writeback effects.
REQ-015 inflight_total and any_pending SHALL reflect the registered counters, with no combinational path from issue or wb inputs.
REQ-016 Register r0-r15 SHALL all be tracked identically; no register is special-cased.

Reset
REQ-017 When rst=1 at a clock edge, the block SHALL:
- clear every pend_cnt to 0;
- clear err_underflow to 0;
- ignore issue_fire and wb_valid in that cycle.
REQ-018 After reset the outputs SHALL be has_hazard=0, dest_full=0, any_pending=0 and inflight_total=0. stall and issue_fire then follow the inputs per REQ-002.
REQ-019 A reset asserted with writes in flight SHALL discard them. Subsequent writebacks for those registers set err_underflow.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Reset, then src1=3, with_src1=1 -> has_hazard=0 and inflight_total=0.
- Issue with dest=5, wb_en=1; next cycle src2=5, with_src2=1 -> has_hazard=1. Then wb_dest=5 -> has_hazard=0 one cycle later.
- CNT_W=2, three issues to r7 -> dest_full=1. Fourth issue to r7 -> stall=1, issue_fire=0, inflight_total stays 3.
- Same-cycle issue and wb to r2 with count 1 -> count stays 1. In that cycle has_hazard=1 for src1=2.
- wb_valid to r9 with count 0 -> err_underflow=1 next cycle and held; rst -> err_underflow=0.
- Issue to r4 and wb to r6 in the same cycle (r6 count 1) -> next cycle counts are r4=1 and r6=0, inflight_total unchanged.
